flow_sequencer: RTL and testbench
=================================

// Module: flow_sequencer
// PURPOSE
//  Top-level phase sequencer for the verify datapath. Runs four phase engines in
//  order: UART receive -> input RAM, verify read of input RAM, H write-back into
//  output RAM, output RAM -> UART transmit. Owns the address/write-enable muxing of
//  both single-port RAMs, applies a per-phase watchdog, and reports status and the
//  latched verify result.
// PARAMETERS
//  ADDR_W      15        RAM address width
//  TMO_W       24        watchdog counter width
//  TMO_CYC     24'hFFFFFF  cycles allowed per phase before error; 0 disables watchdog
//  AUTO_LOOP   1         1: restart at RX after DONE; 0: wait in IDLE for go
// PORTS
//  sys_clk      in   1       single clock
//  sys_rst_n    in   1       asynchronous active-low reset
//  go           in   1       start one pass (used when AUTO_LOOP=0 or after err_clr)
//  err_clr      in   1       leave ERR state
//  rx_end       in   1       RX engine done (level or pulse)
//  vfy_end      in   1       verify engine done
//  vfy_ok       in   1       verify result, valid while vfy_end=1
//  wb_end       in   1       write-back engine done
//  tx_end       in   1       TX engine done
//  rx_start     out  1       level; held until rx_end
//  vfy_start    out  1       level; held until vfy_end
//  wb_start     out  1       level; held until wb_end
//  tx_start     out  1       level; held until tx_end
//  rx_addr      in   ADDR_W  RX engine address;  rx_we  in 1
//  vfy_addr     in   ADDR_W  verify engine read address
//  wb_addr      in   ADDR_W  write-back address; wb_we  in 1
//  tx_addr      in   ADDR_W  TX engine read address
//  ram_in_ena   out  1       input RAM enable
//  ram_in_addr  out  ADDR_W  input RAM address;  ram_in_we  out 1
//  ram_out_ena  out  1       output RAM enable
//  ram_out_addr out  ADDR_W  output RAM address; ram_out_we out 1
//  busy         out  1       state not IDLE/ERR
//  phase        out  3       encoded current state
//  err          out  1       watchdog tripped
//  result_ok    out  1       vfy_ok latched at vfy_end
//  pass_cnt     out  16      completed passes; wraps at 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; watchdog counter 0.
//  States (phase code): IDLE 0, RX 1, TURN1 2, VFY 3, WB 4, TURN2 5, TX 6, DONE 7; ERR is a separate state that reports phase=7 with err=1.
//  IDLE -> RX when AUTO_LOOP=1 (after reset: the first cycle) or when go=1.
//  X_start is registered: rises the cycle after entering phase X; falls in the same edge that
//   samples X_end=1 and moves to the next state. X_end while X_start=0 is ignored.
//  RX -> TURN1 -> (1 cycle) -> VFY -> WB -> TURN2 -> (1 cycle) -> TX -> DONE.
//  VFY exit: result_ok <= vfy_ok. DONE: pass_cnt += 1; -> RX if AUTO_LOOP else IDLE.
//  RAM ownership (combinational from state): ram_in is owned by RX in state RX, and by VFY in TURN1/VFY.
//   ram_out is owned by WB in state WB, and by TX in TURN2/TX. An unowned RAM has addr=0 and we=0.
//   we is always gated by ownership. ram_in_ena/ram_out_ena = 1 in every state except IDLE and ERR.
//  Watchdog: cleared on each state entry. Increments in RX/VFY/WB/TX. Reaching TMO_CYC
//   forces ERR: all starts drop, err=1. An X_end on the same cycle loses to the timeout.
//  ERR -> IDLE on err_clr (err drops); go is ignored in ERR. In IDLE with AUTO_LOOP=1, restart next cycle.
//  Asynchronous reset mid-phase: every start output drops immediately; engines must self-abort.
// STRUCTURE
//  Shared package: state encoding localparams, phase codes, ADDR_W default.
//  One sub-module: flow_watchdog (load/enable/terminal-count counter). Muxes stay inline.
// TESTING
//  AUTO_LOOP=1, ends after 5 cycles each -> starts in order, 1-cycle TURN gaps, pass_cnt=1 at DONE.
//  RX phase, rx_we=1, rx_addr=15'h1234 -> ram_in_addr=15'h1234, we=1; in WB, rx_we=1 -> ram_in_we=0.
//  vfy_end with vfy_ok=1, then next pass with vfy_ok=0 -> result_ok 1 then 0.
//  TMO_CYC=16, withhold wb_end -> err=1 at cycle 16 of WB, wb_start=0; err_clr -> IDLE, restart.
//  Spurious tx_end=1 during RX -> no state change; reset asserted in VFY -> all outputs 0 asynchronously.
//  AUTO_LOOP=0: no go -> stays IDLE with ena=0; go pulse -> one pass, back to IDLE, pass_cnt=1.

Source files
------------

// File: rtl/flow_sequencer_pkg.sv
// Shared definitions for the verify-datapath phase sequencer: state encoding,
// reported phase codes and default RAM address width.
package flow_sequencer_pkg;

    localparam int unsigned FS_ADDR_W = 15;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RX    = 4'd1,
        ST_TURN1 = 4'd2,
        ST_VFY   = 4'd3,
        ST_WB    = 4'd4,
        ST_TURN2 = 4'd5,
        ST_TX    = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERR   = 4'd8
    } fs_state_e;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_RX    = 3'd1;
    localparam logic [2:0] PH_TURN1 = 3'd2;
    localparam logic [2:0] PH_VFY   = 3'd3;
    localparam logic [2:0] PH_WB    = 3'd4;
    localparam logic [2:0] PH_TURN2 = 3'd5;
    localparam logic [2:0] PH_TX    = 3'd6;
    localparam logic [2:0] PH_DONE  = 3'd7;
    localparam logic [2:0] PH_ERR   = 3'd7;

    function automatic logic [2:0] phase_of(input fs_state_e s);
        case (s)
            ST_RX:    return PH_RX;
            ST_TURN1: return PH_TURN1;
            ST_VFY:   return PH_VFY;
            ST_WB:    return PH_WB;
            ST_TURN2: return PH_TURN2;
            ST_TX:    return PH_TX;
            ST_DONE:  return PH_DONE;
            ST_ERR:   return PH_ERR;
            default:  return PH_IDLE;
        endcase
    endfunction

    // Engine-driven phases are the only ones the watchdog times.
    function automatic logic is_work(input fs_state_e s);
        return (s == ST_RX) || (s == ST_VFY) || (s == ST_WB) || (s == ST_TX);
    endfunction

endpackage

// File: rtl/flow_watchdog.sv
// Per-phase watchdog: clearable up-counter with a terminal-count flag.
// LIMIT of zero disables the terminal count.
module flow_watchdog #(
    parameter int unsigned    W     = 24,
    parameter logic [W-1:0]   LIMIT = '1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the cycle whose edge would make the count reach LIMIT.
    assign tc_o = (LIMIT != '0) && en_i && (cnt_q == LIMIT - 1'b1);

endmodule

// File: rtl/flow_sequencer.sv
// Top-level phase sequencer: RX -> verify -> write-back -> TX, with RAM
// ownership muxing, per-phase watchdog and pass/result reporting.
module flow_sequencer
    import flow_sequencer_pkg::*;
#(
    parameter int unsigned      ADDR_W    = FS_ADDR_W,
    parameter int unsigned      TMO_W     = 24,
    parameter logic [TMO_W-1:0] TMO_CYC   = '1,
    parameter bit               AUTO_LOOP = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              go,
    input  logic              err_clr,
    input  logic              rx_end,
    input  logic              vfy_end,
    input  logic              vfy_ok,
    input  logic              wb_end,
    input  logic              tx_end,
    output logic              rx_start,
    output logic              vfy_start,
    output logic              wb_start,
    output logic              tx_start,
    input  logic [ADDR_W-1:0] rx_addr,
    input  logic              rx_we,
    input  logic [ADDR_W-1:0] vfy_addr,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] tx_addr,
    output logic              ram_in_ena,
    output logic [ADDR_W-1:0] ram_in_addr,
    output logic              ram_in_we,
    output logic              ram_out_ena,
    output logic [ADDR_W-1:0] ram_out_addr,
    output logic              ram_out_we,
    output logic              busy,
    output logic [2:0]        phase,
    output logic              err,
    output logic              result_ok,
    output logic [15:0]       pass_cnt
);

    fs_state_e   state_q, state_d;
    logic        rx_start_q, rx_start_d;
    logic        vfy_start_q, vfy_start_d;
    logic        wb_start_q, wb_start_d;
    logic        tx_start_q, tx_start_d;
    logic        result_ok_q, result_ok_d;
    logic [15:0] pass_cnt_q, pass_cnt_d;
    logic        wd_tc;

    flow_watchdog #(
        .W     (TMO_W),
        .LIMIT (TMO_CYC)
    ) u_watchdog (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .load_i (state_d != state_q),
        .en_i   (is_work(state_q)),
        .tc_o   (wd_tc)
    );

    always_comb begin
        state_d     = state_q;
        rx_start_d  = 1'b0;
        vfy_start_d = 1'b0;
        wb_start_d  = 1'b0;
        tx_start_d  = 1'b0;
        result_ok_d = result_ok_q;
        pass_cnt_d  = pass_cnt_q;

        case (state_q)
            ST_IDLE:  if (AUTO_LOOP || go) state_d = ST_RX;
            ST_RX: begin
                if (rx_start_q && rx_end) state_d = ST_TURN1;
                else                      rx_start_d = 1'b1;
            end
            ST_TURN1: state_d = ST_VFY;
            ST_VFY: begin
                if (vfy_start_q && vfy_end) begin
                    state_d     = ST_WB;
                    result_ok_d = vfy_ok;
                end else begin
                    vfy_start_d = 1'b1;
                end
            end
            ST_WB: begin
                if (wb_start_q && wb_end) state_d = ST_TURN2;
                else                      wb_start_d = 1'b1;
            end
            ST_TURN2: state_d = ST_TX;
            ST_TX: begin
                if (tx_start_q && tx_end) begin
                    state_d    = ST_DONE;
                    pass_cnt_d = pass_cnt_q + 16'd1;
                end else begin
                    tx_start_d = 1'b1;
                end
            end
            ST_DONE:  state_d = AUTO_LOOP ? ST_RX : ST_IDLE;
            ST_ERR:   if (err_clr) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Timeout overrides any completion sampled on the same edge.
        if (wd_tc) begin
            state_d     = ST_ERR;
            rx_start_d  = 1'b0;
            vfy_start_d = 1'b0;
            wb_start_d  = 1'b0;
            tx_start_d  = 1'b0;
            result_ok_d = result_ok_q;
            pass_cnt_d  = pass_cnt_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            rx_start_q  <= 1'b0;
            vfy_start_q <= 1'b0;
            wb_start_q  <= 1'b0;
            tx_start_q  <= 1'b0;
            result_ok_q <= 1'b0;
            pass_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rx_start_q  <= rx_start_d;
            vfy_start_q <= vfy_start_d;
            wb_start_q  <= wb_start_d;
            tx_start_q  <= tx_start_d;
            result_ok_q <= result_ok_d;
            pass_cnt_q  <= pass_cnt_d;
        end
    end

    always_comb begin
        ram_in_addr  = '0;
        ram_in_we    = 1'b0;
        ram_out_addr = '0;
        ram_out_we   = 1'b0;
        case (state_q)
            ST_RX: begin
                ram_in_addr = rx_addr;
                ram_in_we   = rx_we;
            end
            ST_TURN1, ST_VFY: ram_in_addr = vfy_addr;
            ST_WB: begin
                ram_out_addr = wb_addr;
                ram_out_we   = wb_we;
            end
            ST_TURN2, ST_TX: ram_out_addr = tx_addr;
            default: ;
        endcase
    end

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign ram_in_ena  = busy;
    assign ram_out_ena = busy;
    assign err         = (state_q == ST_ERR);
    assign phase       = phase_of(state_q);
    assign rx_start    = rx_start_q;
    assign vfy_start   = vfy_start_q;
    assign wb_start    = wb_start_q;
    assign tx_start    = tx_start_q;
    assign result_ok   = result_ok_q;
    assign pass_cnt    = pass_cnt_q;

endmodule

// File: tb/tb_flow_sequencer.sv
// Bench for flow_sequencer: a per-cycle expected schedule built from phase
// durations drives both an auto-loop and a go-triggered instance.
module tb_flow_sequencer;

    typedef struct packed {
        logic [3:0]  st;
        logic [2:0]  phase;
        logic        busy;
        logic        err;
        logic        res;
        logic [15:0] pc;
        logic        in_ena;
        logic [14:0] in_addr;
        logic        in_we;
        logic        out_ena;
        logic [14:0] out_addr;
        logic        out_we;
    } obs_t;

    typedef struct {
        logic [2:0]  phase;
        logic [3:0]  st;
        logic [3:0]  ends;
        logic        ok;
        logic        go;
        logic        clr;
        logic        err;
        logic        res;
        logic [15:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go_a = 1'b0, go_b = 1'b0, err_clr = 1'b0;
    logic        rx_end = 1'b0, vfy_end = 1'b0, vfy_ok = 1'b0, wb_end = 1'b0, tx_end = 1'b0;
    logic [14:0] rx_addr = '0, vfy_addr = '0, wb_addr = '0, tx_addr = '0;
    logic        rx_we = 1'b0, wb_we = 1'b0;

    logic        rx_s_a, vfy_s_a, wb_s_a, tx_s_a, in_ena_a, in_we_a, out_ena_a, out_we_a;
    logic        busy_a, err_a, res_a;
    logic [14:0] in_addr_a, out_addr_a;
    logic [2:0]  phase_a;
    logic [15:0] pc_a;
    logic        rx_s_b, vfy_s_b, wb_s_b, tx_s_b, in_ena_b, in_we_b, out_ena_b, out_we_b;
    logic        busy_b, err_b, res_b;
    logic [14:0] in_addr_b, out_addr_b;
    logic [2:0]  phase_b;
    logic [15:0] pc_b;

    obs_t obs_a, obs_b;
    ent_t sched[$];
    logic        m_res = 1'b0;
    logic [15:0] m_pc = '0;
    int unsigned checks = 0, failures = 0, cyc = 0;

    always #5 clk = ~clk;

    flow_sequencer #(
        .ADDR_W    (15),
        .TMO_W     (24),
        .TMO_CYC   (24'd16),
        .AUTO_LOOP (1'b1)
    ) u_auto (
        .sys_clk (clk), .sys_rst_n (rst_n), .go (go_a), .err_clr (err_clr),
        .rx_end (rx_end), .vfy_end (vfy_end), .vfy_ok (vfy_ok), .wb_end (wb_end), .tx_end (tx_end),
        .rx_start (rx_s_a), .vfy_start (vfy_s_a), .wb_start (wb_s_a), .tx_start (tx_s_a),
        .rx_addr (rx_addr), .rx_we (rx_we), .vfy_addr (vfy_addr), .wb_addr (wb_addr),
        .wb_we (wb_we), .tx_addr (tx_addr),
        .ram_in_ena (in_ena_a), .ram_in_addr (in_addr_a), .ram_in_we (in_we_a),
        .ram_out_ena (out_ena_a), .ram_out_addr (out_addr_a), .ram_out_we (out_we_a),
        .busy (busy_a), .phase (phase_a), .err (err_a), .result_ok (res_a), .pass_cnt (pc_a)
    );

    flow_sequencer #(
        .ADDR_W    (15),
        .TMO_W     (24),
        .TMO_CYC   (24'd0),
        .AUTO_LOOP (1'b0)
    ) u_manual (
        .sys_clk (clk), .sys_rst_n (rst_n), .go (go_b), .err_clr (err_clr),
        .rx_end (rx_end), .vfy_end (vfy_end), .vfy_ok (vfy_ok), .wb_end (wb_end), .tx_end (tx_end),
        .rx_start (rx_s_b), .vfy_start (vfy_s_b), .wb_start (wb_s_b), .tx_start (tx_s_b),
        .rx_addr (rx_addr), .rx_we (rx_we), .vfy_addr (vfy_addr), .wb_addr (wb_addr),
        .wb_we (wb_we), .tx_addr (tx_addr),
        .ram_in_ena (in_ena_b), .ram_in_addr (in_addr_b), .ram_in_we (in_we_b),
        .ram_out_ena (out_ena_b), .ram_out_addr (out_addr_b), .ram_out_we (out_we_b),
        .busy (busy_b), .phase (phase_b), .err (err_b), .result_ok (res_b), .pass_cnt (pc_b)
    );

    always_comb begin
        obs_a = '{st: {tx_s_a, wb_s_a, vfy_s_a, rx_s_a}, phase: phase_a, busy: busy_a, err: err_a,
                  res: res_a, pc: pc_a, in_ena: in_ena_a, in_addr: in_addr_a, in_we: in_we_a,
                  out_ena: out_ena_a, out_addr: out_addr_a, out_we: out_we_a};
        obs_b = '{st: {tx_s_b, wb_s_b, vfy_s_b, rx_s_b}, phase: phase_b, busy: busy_b, err: err_b,
                  res: res_b, pc: pc_b, in_ena: in_ena_b, in_addr: in_addr_b, in_we: in_we_b,
                  out_ena: out_ena_b, out_addr: out_addr_b, out_we: out_we_b};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [3:0] rnd4();
        return 4'($urandom);
    endfunction

    task automatic push(input logic [2:0] ph, input logic [3:0] st, input logic [3:0] en,
                        input logic ok, input logic g, input logic clr, input logic er);
        ent_t e;
        e.phase = ph; e.st = st; e.ends = en; e.ok = ok;
        e.go = g; e.clr = clr; e.err = er; e.res = m_res; e.pc = m_pc;
        sched.push_back(e);
    endtask

    // One engine phase: a cycle with start low (own end ignored), then hold
    // cycles with start high, own end asserted only on the last of them.
    task automatic add_phase(input logic [2:0] ph, input int unsigned idx,
                             input int unsigned hold, input logic ok);
        logic [3:0] own;
        own = 4'(1 << idx);
        push(ph, 4'b0, rnd4(), 1'($urandom), 1'b0, 1'b0, 1'b0);
        for (int unsigned i = 1; i <= hold; i++) begin
            push(ph, own, (rnd4() & ~own) | ((i == hold) ? own : 4'b0),
                 (i == hold) ? ok : 1'($urandom), 1'b0, 1'b0, 1'b0);
        end
        if (ph == 3'd3) m_res = ok;
    endtask

    task automatic add_pass(input int unsigned hrx, input int unsigned hvfy,
                            input int unsigned hwb, input int unsigned htx, input logic ok);
        add_phase(3'd1, 0, hrx, 1'b0);
        push(3'd2, 4'b0, rnd4(), 1'($urandom), 1'b0, 1'b0, 1'b0);
        add_phase(3'd3, 1, hvfy, ok);
        add_phase(3'd4, 2, hwb, 1'b0);
        push(3'd5, 4'b0, rnd4(), 1'($urandom), 1'b0, 1'b0, 1'b0);
        add_phase(3'd6, 3, htx, 1'b0);
        m_pc = m_pc + 16'd1;
        push(3'd7, 4'b0, rnd4(), 1'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_sched(input bit sel, input int unsigned limit);
        ent_t        e;
        obs_t        o;
        logic        own_in, own_out;
        int unsigned n;
        n = 0;
        while (sched.size() > 0 && n < limit) begin
            e = sched.pop_front();
            n++;
            @(negedge clk);
            {tx_end, wb_end, vfy_end, rx_end} = e.ends;
            vfy_ok   = e.ok;
            err_clr  = e.clr;
            go_a     = sel ? 1'b0 : e.go;
            go_b     = sel ? e.go : 1'b0;
            rx_addr  = 15'($urandom);
            vfy_addr = 15'($urandom);
            wb_addr  = 15'($urandom);
            tx_addr  = 15'($urandom);
            rx_we    = 1'($urandom);
            wb_we    = 1'($urandom);
            #1;
            cyc++;
            o = sel ? obs_b : obs_a;
            own_in  = !e.err && (e.phase == 3'd1 || e.phase == 3'd2 || e.phase == 3'd3);
            own_out = !e.err && (e.phase == 3'd4 || e.phase == 3'd5 || e.phase == 3'd6);
            chk("phase",    64'(o.phase), 64'(e.phase));
            chk("starts",   64'(o.st), 64'(e.st));
            chk("err",      64'(o.err), 64'(e.err));
            chk("busy",     64'(o.busy), 64'(e.phase != 3'd0 && !e.err));
            chk("in_ena",   64'(o.in_ena), 64'(e.phase != 3'd0 && !e.err));
            chk("out_ena",  64'(o.out_ena), 64'(e.phase != 3'd0 && !e.err));
            chk("result",   64'(o.res), 64'(e.res));
            chk("pass_cnt", 64'(o.pc), 64'(e.pc));
            chk("in_addr",  64'(o.in_addr),
                64'(own_in ? ((e.phase == 3'd1) ? rx_addr : vfy_addr) : 15'd0));
            chk("in_we",    64'(o.in_we), 64'(own_in && e.phase == 3'd1 && rx_we));
            chk("out_addr", 64'(o.out_addr),
                64'(own_out ? ((e.phase == 3'd4) ? wb_addr : tx_addr) : 15'd0));
            chk("out_we",   64'(o.out_we), 64'(own_out && e.phase == 3'd4 && wb_we));
            if (!sel) chk("b_idle", 64'({obs_b.phase, obs_b.busy, obs_b.in_ena, obs_b.out_ena}), 64'd0);
        end
    endtask

    initial begin
        // Reset with owner-looking inputs active: outputs must stay zero.
        rx_addr = 15'h1234; rx_we = 1'b1; wb_addr = 15'h0abc; wb_we = 1'b1; go_b = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_a", 64'(obs_a), 64'd0);
        chk("reset_b", 64'(obs_b), 64'd0);
        go_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        add_pass(4, 4, 4, 4, 1'b1);
        add_pass(4, 4, 4, 4, 1'b0);
        for (int unsigned p = 0; p < 3; p++) begin
            add_pass($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8),
                     $urandom_range(1, 8), 1'($urandom));
        end
        run_sched(1'b0, 100000);

        // Watchdog: WB end withheld until the 16th cycle, where it loses to the timeout.
        add_phase(3'd1, 0, 3, 1'b0);
        push(3'd2, 4'b0, rnd4(), 1'b0, 1'b0, 1'b0, 1'b0);
        add_phase(3'd3, 1, 2, 1'b1);
        add_phase(3'd4, 2, 15, 1'b0);
        for (int unsigned i = 0; i < 3; i++) push(3'd7, 4'b0, rnd4(), 1'b0, 1'b1, 1'b0, 1'b1);
        push(3'd7, 4'b0, rnd4(), 1'b0, 1'b0, 1'b1, 1'b1);
        push(3'd0, 4'b0, rnd4(), 1'b0, 1'b0, 1'b0, 1'b0);
        add_pass(3, 2, 5, 1, 1'b1);
        run_sched(1'b0, 100000);

        // Stop partway: RX(1+2), TURN1, VFY entry, first VFY cycle with start high.
        add_pass(2, 3, 2, 2, 1'b1);
        run_sched(1'b0, 6);
        sched.delete();
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_a", 64'(obs_a), 64'd0);
        chk("async_rst_b", 64'(obs_b), 64'd0);
        m_res = 1'b0;
        m_pc  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Manual instance: idle until go, one pass (RX outlasts 16 cycles), back to idle.
        for (int unsigned i = 0; i < 3; i++) push(3'd0, 4'b0, rnd4(), 1'b0, 1'b0, 1'b0, 1'b0);
        push(3'd0, 4'b0, rnd4(), 1'b0, 1'b1, 1'b0, 1'b0);
        add_pass(20, 3, 2, 5, 1'b1);
        for (int unsigned i = 0; i < 4; i++) push(3'd0, 4'b0, rnd4(), 1'b0, 1'b0, 1'b0, 1'b0);
        run_sched(1'b1, 100000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
